bcd_scan_sequencer: RTL and testbench
=====================================

# bcd_scan_sequencer

Scan controller for the BCD-to-decimal strobe decoder that selects the player-input and DIP-switch matrix rows. It steps a 4-bit BCD select through the active rows, holds each select for a fixed dwell so that the decoder output and the matrix lines settle, then samples the shared sense line. Each row's sample is debounced into a 10-bit status vector. It also accepts a single-row read request from the CPU I/O decode and interleaves it with the background scan.

## Interface
Parameters:
- SLOTS, 10: number of scanned rows (1..10); rows run 0..SLOTS-1.
- DWELL, 16: cycles each select is held (min 2); the sense line is sampled on the last dwell cycle.
- DEBOUNCE, 3: consecutive equal samples required to change a status bit (1..7).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  scan run; when low, the block finishes the current slot and then parks.
- bcd  out  4  select code to the decoder (bit0 = a … bit3 = d); 4'hF means blank, all decoder outputs deasserted.
- sense  in  1  matrix return line, active-low (0 = row contact closed); already synchronised.
- status  out  10  debounced row state, 1 = closed; bits at index ≥SLOTS are held 0.
- scan_wrap  out  1  one-cycle pulse when the last sample of row SLOTS-1 is taken.
- cpu_req  in  1  level request, held high until cpu_ack.
- cpu_slot  in  4  row requested; latched in the cycle the request is accepted.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_data  out  1  raw (not debounced) sample for the requested row, 1 = closed; valid in the cpu_ack cycle and held until the next ack.

## Operation
- FSM states: PARK, SCAN, CPU.
  - PARK: bcd = F; dwell counter cleared.
  - SCAN: bcd = row index.
  - CPU: bcd = latched cpu_slot, or F if cpu_slot > 9.
- Reset values: state PARK, bcd = F, row = 0, dwell = 0, status = 0, debounce counters 0, scan_wrap/cpu_ack/cpu_data = 0.
- Dwell counter runs 0..DWELL-1 in SCAN and CPU. At DWELL-1 the block samples ~sense and ends the slot.
- End of a SCAN slot, in priority order:
  1. If cpu_req = 1, go to CPU and latch cpu_slot.
  2. Else if enable = 0, go to PARK.
  3. Else stay in SCAN and advance row. Row wraps SLOTS-1 → 0 and pulses scan_wrap.
- PARK to SCAN or CPU: on a cycle with enable = 1 or cpu_req = 1 (cpu_req wins). Row resumes at its stored value.
- CPU slot end: cpu_data = sample and cpu_ack = 1. Next state is SCAN at the next row if enable = 1, else PARK. The CPU sample does not feed the debouncer.
- A request is never accepted mid-slot. Worst-case ack latency is 2·DWELL cycles after the rising edge of cpu_req.
- cpu_req still high in the cycle after cpu_ack starts a new request. Requesters must drop cpu_req on ack.
- Debounce, one 3-bit counter per row:
  - Sample equal to status[row]: counter cleared.
  - Sample different: counter increments. When it reaches DEBOUNCE, status[row] flips and the counter clears.
- enable dropping mid-slot does not truncate the slot.
- Reset assertion at any point returns all outputs to their reset values asynchronously. A pending CPU request is lost and not acked.

## Timing
- bcd changes only at a slot boundary, registered. In SCAN it changes on the same edge that samples the previous slot.
- Sample edge is dwell = DWELL-1. status updates on that edge, so it is visible the next cycle.
- Continuous scan period is SLOTS·DWELL cycles. The scan_wrap interval stretches by DWELL per CPU slot inserted.
- PARK → first sample: DWELL cycles after the transition edge.

## Structure
- Shared package (io_pkg): BCD_BLANK = 4'hF, MAX_SLOTS = 10, and the FSM state enum.
- One sub-module, scan_debounce: a per-row counter bank with inputs (row, sample, strobe) and output status.
- The top level contains the FSM, dwell counter, row counter and CPU latch.

## Test plan
- Reset, then enable = 1 with sense = 1 (DWELL = 16, SLOTS = 10) → bcd runs 0,1,…,9,0, each held 16 cycles; scan_wrap pulses every 160 cycles; status stays 0.
- Row 3 closed (sense = 0 whenever bcd = 3), DEBOUNCE = 3 → status[3] sets on the third row-3 sample, two full scans after the first. A single open glitch on one sample does not clear it.
- cpu_req with cpu_slot = 7 raised mid-row 2 → row 2 completes, bcd = 7 for 16 cycles, cpu_ack pulses with cpu_data = 1 (row 7 closed), scan resumes at row 3.
- cpu_slot = 12 → bcd = F for DWELL cycles, cpu_ack with cpu_data = 0 (sense idle high).
- enable dropped at dwell 5 of row 4 → row 4 completes and is sampled, then bcd = F. Re-enable → scan resumes at row 5.
- reset_n pulsed low mid-CPU slot → bcd = F immediately, status = 0, no cpu_ack; after release the block stays in PARK until enable or cpu_req.

Source files
------------

// File: rtl/bcd_scan_sequencer_pkg.sv
// Shared definitions for the I/O matrix scan sequencer: blank code, row limit, FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package io_pkg;

  // Decoder select code that deasserts every strobe output.
  localparam logic [3:0] BCD_BLANK = 4'hF;
  // Width of the status vector; the decoder has ten outputs.
  localparam int MAX_SLOTS = 10;

  typedef enum logic [1:0] {
    ST_PARK = 2'd0,
    ST_SCAN = 2'd1,
    ST_CPU  = 2'd2
  } scan_state_e;

  // Select code for a CPU read: rows the decoder does not have are driven blank.
  function automatic logic [3:0] cpu_code(input logic [3:0] slot);
    return (slot > 4'd9) ? BCD_BLANK : slot;
  endfunction

endpackage

// File: rtl/bcd_scan_sequencer_if.sv
// Bundle of the scan sequencer's matrix, status and CPU-read signals.
// Latency: n/a (wiring only).
// Backpressure: CPU side is a level request held until the one-cycle ack.
interface bcd_scan_sequencer_if;
  import io_pkg::*;

  logic                 enable;
  logic [3:0]           bcd;
  logic                 sense;
  logic [MAX_SLOTS-1:0] status;
  logic                 scan_wrap;
  logic                 cpu_req;
  logic [3:0]           cpu_slot;
  logic                 cpu_ack;
  logic                 cpu_data;

  // Sequencer side.
  modport master (
    input  enable, sense, cpu_req, cpu_slot,
    output bcd, status, scan_wrap, cpu_ack, cpu_data
  );

  // Matrix / CPU decode side.
  modport slave (
    output enable, sense, cpu_req, cpu_slot,
    input  bcd, status, scan_wrap, cpu_ack, cpu_data
  );

endinterface

// File: rtl/bcd_scan_sequencer_debounce.sv
// Per-row debounce bank: a status bit flips after DEBOUNCE consecutive differing samples.
// Latency: status updates on the strobe edge, visible the following cycle.
// Backpressure: none; one sample per strobe is always absorbed.
module scan_debounce
  import io_pkg::*;
#(
  parameter int SLOTS    = 10,
  parameter int DEBOUNCE = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [3:0]           row_i,
  input  logic                 sample_i,
  input  logic                 strobe_i,
  output logic [MAX_SLOTS-1:0] status_o
);

  logic [2:0]           cnt_q [MAX_SLOTS];
  logic [2:0]           cnt_d [MAX_SLOTS];
  logic [MAX_SLOTS-1:0] status_q;
  logic [MAX_SLOTS-1:0] status_d;

  // Only the strobed row moves; an agreeing sample resets its run of disagreements.
  always_comb begin
    cnt_d    = cnt_q;
    status_d = status_q;
    for (int r = 0; r < MAX_SLOTS; r++) begin
      if (strobe_i && (row_i == 4'(r)) && (r < SLOTS)) begin
        if (sample_i == status_q[r]) begin
          cnt_d[r] = 3'd0;
        end else if ((cnt_q[r] + 3'd1) == 3'(DEBOUNCE)) begin
          status_d[r] = ~status_q[r];
          cnt_d[r]    = 3'd0;
        end else begin
          cnt_d[r] = cnt_q[r] + 3'd1;
        end
      end
    end
  end

  // Counter bank and status register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      status_q <= '0;
      cnt_q    <= '{default: 3'd0};
    end else begin
      status_q <= status_d;
      cnt_q    <= cnt_d;
    end
  end

  assign status_o = status_q;

endmodule

// File: rtl/bcd_scan_sequencer.sv
// Steps the BCD strobe select through the matrix rows, samples sense at the end of each dwell, interleaves CPU reads.
// Latency: sample taken DWELL cycles after a slot starts; CPU ack within 2*DWELL cycles of request.
// Backpressure: CPU request is only accepted at a slot boundary (or from PARK) and held by the requester until ack.
module bcd_scan_sequencer
  import io_pkg::*;
#(
  parameter int SLOTS    = 10,
  parameter int DWELL    = 16,
  parameter int DEBOUNCE = 3
) (
  input logic                  clk,
  input logic                  reset_n,
  bcd_scan_sequencer_if.master bus
);

  localparam int              DW         = $clog2(DWELL);
  localparam logic [DW-1:0]   DWELL_LAST = DW'(DWELL - 1);
  localparam logic [3:0]      ROW_LAST   = 4'(SLOTS - 1);

  scan_state_e          state_q, state_d;
  logic [DW-1:0]        dwell_q, dwell_d;
  logic [3:0]           row_q, row_d;
  logic [3:0]           slot_q, slot_d;
  logic [3:0]           bcd_q, bcd_d;
  logic                 scan_wrap_q, scan_wrap_d;
  logic                 cpu_ack_q, cpu_ack_d;
  logic                 cpu_data_q, cpu_data_d;
  logic                 slot_end;
  logic                 accept;
  logic                 scan_strobe;
  logic [MAX_SLOTS-1:0] status_w;

  // Last dwell cycle of an active slot: sample edge and slot boundary coincide.
  assign slot_end    = (state_q != ST_PARK) && (dwell_q == DWELL_LAST);
  assign scan_strobe = (state_q == ST_SCAN) && slot_end;
  assign accept      = (state_d == ST_CPU) && (state_q != ST_CPU);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_PARK;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: CPU request beats scan run; slots are never cut short.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_PARK: begin
        if (bus.cpu_req)     state_d = ST_CPU;
        else if (bus.enable) state_d = ST_SCAN;
      end
      ST_SCAN: begin
        if (slot_end) begin
          if (bus.cpu_req)      state_d = ST_CPU;
          else if (!bus.enable) state_d = ST_PARK;
        end
      end
      ST_CPU: begin
        if (slot_end) state_d = bus.enable ? ST_SCAN : ST_PARK;
      end
      default: state_d = ST_PARK;
    endcase
  end

  // Dwell, row and CPU-slot next values; row advances after every scan sample.
  always_comb begin
    dwell_d = ((state_q == ST_PARK) || slot_end) ? '0 : dwell_q + DW'(1);
    row_d   = row_q;
    if (scan_strobe) row_d = (row_q == ROW_LAST) ? 4'd0 : row_q + 4'd1;
    slot_d  = accept ? bus.cpu_slot : slot_q;
  end

  // Registered outputs follow the state being entered so bcd moves on the sample edge.
  always_comb begin
    unique case (state_d)
      ST_SCAN: bcd_d = row_d;
      ST_CPU:  bcd_d = cpu_code(slot_d);
      default: bcd_d = BCD_BLANK;
    endcase
    scan_wrap_d = scan_strobe && (row_q == ROW_LAST);
    cpu_ack_d   = (state_q == ST_CPU) && slot_end;
    cpu_data_d  = cpu_ack_d ? ~bus.sense : cpu_data_q;
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dwell_q     <= '0;
      row_q       <= 4'd0;
      slot_q      <= 4'd0;
      bcd_q       <= BCD_BLANK;
      scan_wrap_q <= 1'b0;
      cpu_ack_q   <= 1'b0;
      cpu_data_q  <= 1'b0;
    end else begin
      dwell_q     <= dwell_d;
      row_q       <= row_d;
      slot_q      <= slot_d;
      bcd_q       <= bcd_d;
      scan_wrap_q <= scan_wrap_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_data_q  <= cpu_data_d;
    end
  end

  // CPU samples are raw and never reach the debouncer.
  scan_debounce #(
    .SLOTS    (SLOTS),
    .DEBOUNCE (DEBOUNCE)
  ) u_debounce (
    .clk      (clk),
    .reset_n  (reset_n),
    .row_i    (row_q),
    .sample_i (~bus.sense),
    .strobe_i (scan_strobe),
    .status_o (status_w)
  );

  assign bus.bcd       = bcd_q;
  assign bus.status    = status_w;
  assign bus.scan_wrap = scan_wrap_q;
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.cpu_data  = cpu_data_q;

endmodule

// File: tb/tb_bcd_scan_sequencer.sv
// Randomised and directed bench for the scan sequencer against a slot-level reference model.
// Latency: model predicts outputs per cycle; compared on every falling edge.
// Backpressure: bench requester holds cpu_req until it sees cpu_ack.
module tb_bcd_scan_sequencer;

  localparam int SLOTS = 10;
  localparam int DWELL = 16;
  localparam int DEB   = 3;
  localparam int PARK  = 0;
  localparam int SCAN  = 1;
  localparam int CPU   = 2;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  bcd_scan_sequencer_if bif();

  bcd_scan_sequencer #(
    .SLOTS    (SLOTS),
    .DWELL    (DWELL),
    .DEBOUNCE (DEB)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bif)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Matrix: closed_mask[row] = contact closed; noise only in the random phase.
  logic [15:0] closed_mask = 16'h0000;
  bit          rand_mode   = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model (slot-level countdown) ----------------
  int m_mode;
  int m_left;
  int m_row;
  int m_slot;
  int m_diff [SLOTS];
  bit m_stat [SLOTS];
  bit m_wrap, m_ack, m_data;

  task automatic model_reset();
    m_mode = PARK; m_left = 0; m_row = 0; m_slot = 0;
    m_wrap = 0; m_ack = 0; m_data = 0;
    for (int r = 0; r < SLOTS; r++) begin
      m_diff[r] = 0;
      m_stat[r] = 0;
    end
  endtask

  task automatic model_edge();
    bit closed;
    m_wrap = 0;
    m_ack  = 0;
    if (m_mode == PARK) begin
      if (bif.cpu_req) begin
        m_mode = CPU; m_slot = int'(bif.cpu_slot); m_left = DWELL;
      end else if (bif.enable) begin
        m_mode = SCAN; m_left = DWELL;
      end
    end else begin
      m_left--;
      if (m_left == 0) begin
        closed = !bif.sense;
        m_left = DWELL;
        if (m_mode == SCAN) begin
          if (closed == m_stat[m_row]) m_diff[m_row] = 0;
          else begin
            m_diff[m_row]++;
            if (m_diff[m_row] == DEB) begin
              m_stat[m_row] = closed;
              m_diff[m_row] = 0;
            end
          end
          if (m_row == SLOTS - 1) m_wrap = 1;
          m_row = (m_row + 1) % SLOTS;
          if (bif.cpu_req) begin
            m_mode = CPU; m_slot = int'(bif.cpu_slot);
          end else if (!bif.enable) begin
            m_mode = PARK;
          end
        end else begin
          m_ack  = 1;
          m_data = closed;
          m_mode = bif.enable ? SCAN : PARK;
        end
      end
    end
  endtask

  function automatic int exp_bcd();
    if (m_mode == SCAN) return m_row;
    if (m_mode == CPU)  return (m_slot > 9) ? 15 : m_slot;
    return 15;
  endfunction

  function automatic int exp_status();
    int v = 0;
    for (int r = 0; r < SLOTS; r++) if (m_stat[r]) v = v | (1 << r);
    return v;
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else          model_edge();
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      check("bcd",       int'(bif.bcd),       exp_bcd());
      check("status",    int'(bif.status),    exp_status());
      check("scan_wrap", int'(bif.scan_wrap), int'(m_wrap));
      check("cpu_ack",   int'(bif.cpu_ack),   int'(m_ack));
      check("cpu_data",  int'(bif.cpu_data),  int'(m_data));
    end
  end

  // Sense follows the selected row, settled one unit after the edge.
  initial begin
    bif.sense = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rand_mode)
        bif.sense = ~(closed_mask[bif.bcd] ^ ($urandom_range(0, 7) == 0));
      else
        bif.sense = ~closed_mask[bif.bcd];
    end
  end

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      if (rand_mode && ($urandom_range(0, 63) == 0)) bif.enable = ~bif.enable;
    end
  endtask

  task automatic wait_enter(input int val, input int budget, input string name, output int n);
    bit left_val;
    bit found;
    left_val = (int'(bif.bcd) != val);
    found    = 0;
    n        = 0;
    while (!found && n < budget) begin
      step(1);
      n++;
      if (int'(bif.bcd) != val) left_val = 1;
      else if (left_val)        found    = 1;
    end
    check(name, int'(found), 1);
  endtask

  task automatic wait_wrap(input string name, output int t);
    bit found;
    int n;
    found = 0; n = 0; t = 0;
    while (!found && n < 2 * SLOTS * DWELL) begin
      step(1);
      n++;
      if (bif.scan_wrap) begin found = 1; t = cyc; end
    end
    check(name, int'(found), 1);
  endtask

  task automatic cpu_read(input int slot, output int data, output int lat, output int run, output int bcd_after);
    int code;
    bit got;
    code = (slot > 9) ? 15 : slot;
    got = 0; lat = 0; run = 0; data = 0; bcd_after = 0;
    bif.cpu_slot = 4'(slot);
    bif.cpu_req  = 1'b1;
    while (!got && lat < 4 * DWELL) begin
      step(1);
      lat++;
      if (bif.cpu_ack) begin
        got = 1; data = int'(bif.cpu_data); bcd_after = int'(bif.bcd);
      end else begin
        run = (int'(bif.bcd) == code) ? run + 1 : 0;
      end
    end
    bif.cpu_req = 1'b0;
    check("cpu_ack_seen", int'(got), 1);
    if (got) check("cpu_ack_within_2dwell", int'(lat <= 2 * DWELL), 1);
  endtask

  // ---------------- directed then random sequence ----------------
  initial begin
    int t1, t2, n, d, lat, run, ba, acks, lit;
    bif.enable = 1'b0; bif.cpu_req = 1'b0; bif.cpu_slot = 4'd0;
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b1;
    check("rst_bcd",    int'(bif.bcd),    15);
    check("rst_status", int'(bif.status), 0);
    check("rst_ack",    int'(bif.cpu_ack), 0);
    step(8);
    check("park_hold_bcd", int'(bif.bcd), 15);

    // Free-running scan with all rows open.
    bif.enable = 1'b1;
    step(1);
    check("first_row_bcd", int'(bif.bcd), 0);
    wait_wrap("wrap1_seen", t1);
    wait_wrap("wrap2_seen", t2);
    check("wrap_period", t2 - t1, SLOTS * DWELL);
    check("open_status", int'(bif.status), 0);

    // Row 3 closed: third consecutive sample sets status[3].
    wait_enter(3, 400, "enter_row3", n);
    closed_mask[3] = 1'b1;
    t1 = cyc;
    n  = 0;
    while (!bif.status[3] && n < 600) begin step(1); n++; end
    check("row3_set_latency", cyc - t1, 2 * SLOTS * DWELL + DWELL);
    check("row3_status", int'(bif.status), 10'h008);

    // One open glitch must not clear it.
    wait_enter(3, 400, "enter_row3_glitch", n);
    closed_mask[3] = 1'b0;
    wait_enter(4, 40, "enter_row4_glitch", n);
    closed_mask[3] = 1'b1;
    check("glitch_hold", int'(bif.status), 10'h008);
    step(2 * SLOTS * DWELL);
    check("glitch_hold_late", int'(bif.status), 10'h008);

    // CPU read of row 7 raised mid-row 2.
    closed_mask[7] = 1'b1;
    wait_enter(2, 400, "enter_row2", n);
    step(5);
    cpu_read(7, d, lat, run, ba);
    check("cpu7_data", d, 1);
    check("cpu7_latency", lat, 27);
    check("cpu7_dwell", run, DWELL);
    check("cpu7_resume_row", ba, 3);

    // CPU read of a row the decoder lacks.
    step(3);
    cpu_read(12, d, lat, run, ba);
    check("cpu12_data", d, 0);
    check("cpu12_blank_dwell", run, DWELL);

    // Drop enable at dwell 5 of row 4.
    wait_enter(4, 400, "enter_row4", n);
    step(5);
    bif.enable = 1'b0;
    wait_enter(15, 40, "enter_park", n);
    check("park_after_row4", n, 11);
    step(10);
    check("parked_bcd", int'(bif.bcd), 15);
    bif.enable = 1'b1;
    step(1);
    check("resume_row5", int'(bif.bcd), 5);

    // Reset in the middle of a CPU slot.
    bif.cpu_slot = 4'd13;
    bif.cpu_req  = 1'b1;
    wait_enter(15, 40, "enter_cpu13", n);
    step(4);
    bif.enable = 1'b0;
    reset_n    = 1'b0;
    #1;
    check("rstcpu_bcd",    int'(bif.bcd),      15);
    check("rstcpu_status", int'(bif.status),   0);
    check("rstcpu_ack",    int'(bif.cpu_ack),  0);
    check("rstcpu_data",   int'(bif.cpu_data), 0);
    step(2);
    bif.cpu_req = 1'b0;
    reset_n     = 1'b1;
    acks = 0; lit = 0;
    for (int i = 0; i < 3 * DWELL; i++) begin
      step(1);
      if (bif.cpu_ack) acks++;
      if (bif.bcd != 4'hF) lit++;
    end
    check("rstcpu_no_ack", acks, 0);
    check("rstcpu_stays_park", lit, 0);

    // Random phase: noisy matrix, wandering enable, CPU reads of any slot.
    rand_mode  = 1'b1;
    bif.enable = 1'b1;
    for (int i = 0; i < 150; i++) begin
      if ((i % 10) == 0) closed_mask = 16'($urandom) & 16'h03FF;
      step($urandom_range(1, 60));
      cpu_read($urandom_range(0, 15), d, lat, run, ba);
    end
    rand_mode = 1'b0;
    step(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
